// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings (HTRANS, HSIZE, HBURST, HRESP) and the sequencing
// master's FSM state enum, plus a small response-classification helper.
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_REQ  = 3'b001,
        ST_XFER = 3'b010,
        ST_LAST = 3'b011,
        ST_DONE = 3'b100
    } state_e;

    localparam logic [3:0] HPROT_DEFAULT = 4'b0000;

    // RETRY and SPLIT are not supported by this master, so any non-OKAY
    // response is handled as a fault.
    function automatic logic resp_is_fault(input logic [1:0] resp);
        return (resp != HRESP_OKAY);
    endfunction

endpackage

// File: rtl/ahb_beat_gen.sv
// ---------------------------------------------------------------------------
// ahb_beat_gen
// Holds the address, write data and beat index of the beat currently waiting
// for its address phase.
//   clk, rst : clock and synchronous active-high reset
//   load     : restart at beat 0 (BASE_ADDR / DATA_INIT)
//   advance  : current beat's address phase completed, step to next beat
//   addr     : address of the current beat
//   data     : write data belonging to the current beat
//   last     : current beat is beat NUM_BEATS-1
// ---------------------------------------------------------------------------
module ahb_beat_gen
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          NUM_BEATS = 4,
    parameter int          ADDR_INC  = 0,
    parameter logic [31:0] DATA_INIT = 32'h0000_0031,
    parameter logic [31:0] DATA_STEP = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic        last
);

    localparam int          BEAT_W    = $clog2(NUM_BEATS + 1);
    localparam logic [31:0] ADDR_STEP = (ADDR_INC != 0) ? 32'd4 : 32'd0;

    logic [31:0]       addr_r;
    logic [31:0]       data_r;
    logic [BEAT_W-1:0] beat_r;

    // Beat state: reload on reset/start, step on each completed address phase.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            addr_r <= BASE_ADDR;
            data_r <= DATA_INIT;
            beat_r <= '0;
        end else if (advance) begin
            addr_r <= addr_r + ADDR_STEP;   // wraps modulo 2^32
            data_r <= data_r + DATA_STEP;   // wraps modulo 2^32
            beat_r <= beat_r + BEAT_W'(1);
        end
    end

    assign addr = addr_r;
    assign data = data_r;
    assign last = (beat_r == BEAT_W'(NUM_BEATS - 1));

endmodule

// File: rtl/ahb_seq_master.sv
// ---------------------------------------------------------------------------
// ahb_seq_master
// AHB master that issues NUM_BEATS single word writes (pipelined, one beat
// per cycle at zero wait states) per start request.
//   HCLK, HRESET         : clock, synchronous active-high reset
//   HREADYM, HGRANTM     : bus ready and arbiter grant
//   HRESPM               : slave response (non-OKAY aborts the run)
//   start                : one-cycle run request, honoured only when idle
//   HADDRM..HBUSREQM     : AHB master outputs
//   busy, done, err      : run active, one-cycle completion pulse, sticky error
// ---------------------------------------------------------------------------
module ahb_seq_master
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          NUM_BEATS  = 4,
    parameter int          ADDR_INC   = 0,
    parameter logic [31:0] DATA_INIT  = 32'h0000_0031,
    parameter logic [31:0] DATA_STEP  = 32'h0000_0001,
    parameter int          CONTINUOUS = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HREADYM,
    input  logic        HGRANTM,
    input  logic [1:0]  HRESPM,
    input  logic        start,
    output logic [31:0] HADDRM,
    output logic [31:0] HWDATAM,
    output logic [1:0]  HTRANSM,
    output logic        HWRITEM,
    output logic [2:0]  HSIZEM,
    output logic [2:0]  HBURSTM,
    output logic [3:0]  HPROTM,
    output logic        HBUSREQM,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e      state_r;
    state_e      state_s;
    htrans_e     htrans_r;
    logic        busreq_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        err_pend_r;
    logic        dphase_r;
    logic [31:0] hwdata_r;

    logic        load_s;
    logic        advance_s;
    logic        err_pend_set_s;
    logic        fault_s;
    logic [31:0] addr_s;
    logic [31:0] data_s;
    logic        last_s;

    ahb_beat_gen #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_BEATS (NUM_BEATS),
        .ADDR_INC  (ADDR_INC),
        .DATA_INIT (DATA_INIT),
        .DATA_STEP (DATA_STEP)
    ) u_beat_gen (
        .clk     (HCLK),
        .rst     (HRESET),
        .load    (load_s),
        .advance (advance_s),
        .addr    (addr_s),
        .data    (data_s),
        .last    (last_s)
    );

    // First cycle of a two-cycle fault response during one of our data phases.
    assign fault_s = dphase_r && resp_is_fault(HRESPM) && !HREADYM;

    // Next-state and per-edge control decisions.
    always_comb begin
        state_s        = state_r;
        load_s         = 1'b0;
        advance_s      = 1'b0;
        err_pend_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_REQ;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A data phase from before a lost grant may still be open.
                if (fault_s) begin
                    state_s        = ST_LAST;
                    err_pend_set_s = 1'b1;
                end else if (HREADYM && HGRANTM) begin
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (fault_s) begin
                    // Withdraw the pending NONSEQ; nothing is retried.
                    state_s        = ST_LAST;
                    err_pend_set_s = 1'b1;
                end else if (HREADYM) begin
                    if (HGRANTM) begin
                        advance_s = 1'b1;
                        state_s   = last_s ? ST_LAST : ST_XFER;
                    end else begin
                        // Bus lost: beat not taken, it is reissued after regrant.
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_LAST: begin
                if (HREADYM) begin
                    state_s = ST_DONE;
                end else begin
                    state_s        = ST_LAST;
                    err_pend_set_s = fault_s;
                end
            end
            ST_DONE: begin
                if (CONTINUOUS != 0) begin
                    state_s = ST_REQ;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and state-decoded outputs, registered from next state.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r  <= ST_IDLE;
            htrans_r <= HTRANS_IDLE;
            busreq_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            htrans_r <= (state_s == ST_XFER) ? HTRANS_NONSEQ : HTRANS_IDLE;
            busreq_r <= (state_s == ST_REQ) || (state_s == ST_XFER);
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= (state_s == ST_DONE);
        end
    end

    // Write data pipeline: data follows its address phase by one cycle and
    // holds through wait states until the next address phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hwdata_r <= 32'h0000_0000;
            dphase_r <= 1'b0;
        end else begin
            if (advance_s) begin
                hwdata_r <= data_s;
            end
            if (advance_s) begin
                dphase_r <= 1'b1;
            end else if (HREADYM) begin
                dphase_r <= 1'b0;
            end
        end
    end

    // Error tracking: pending after a fault, reported when the run reaches DONE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_pend_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (load_s) begin
            err_pend_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (err_pend_set_s) begin
                err_pend_r <= 1'b1;
            end
            if ((state_r == ST_LAST) && (state_s == ST_DONE) && err_pend_r) begin
                err_r <= 1'b1;
            end
        end
    end

    assign HADDRM   = addr_s;
    assign HWDATAM  = hwdata_r;
    assign HTRANSM  = htrans_r;
    assign HBUSREQM = busreq_r;
    assign HWRITEM  = 1'b1;
    assign HSIZEM   = HSIZE_WORD;
    assign HBURSTM  = HBURST_SINGLE;
    assign HPROTM   = HPROT_DEFAULT;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_ahb_seq_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_seq_master
// Two masters: index 0 with default parameters, index 1 with ADDR_INC=1 and
// NUM_BEATS=3. A transaction-level model predicts the beat sequence
// (address BASE + 4*i*ADDR_INC, data 0x31 + i), done/err/busy and bus rules.
// ---------------------------------------------------------------------------
module tb_ahb_seq_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HREADYM;
    logic        HGRANTM;
    logic [1:0]  resp_m   [2];
    logic        start_m  [2];
    logic [31:0] haddr_m  [2];
    logic [31:0] hwdata_m [2];
    logic [1:0]  htrans_m [2];
    logic        hwrite_m [2];
    logic [2:0]  hsize_m  [2];
    logic [2:0]  hburst_m [2];
    logic [3:0]  hprot_m  [2];
    logic        busreq_m [2];
    logic        busy_m   [2];
    logic        done_m   [2];
    logic        err_m    [2];

    always #5 HCLK = ~HCLK;

    ahb_seq_master u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HREADYM(HREADYM), .HGRANTM(HGRANTM),
        .HRESPM(resp_m[0]), .start(start_m[0]),
        .HADDRM(haddr_m[0]), .HWDATAM(hwdata_m[0]), .HTRANSM(htrans_m[0]),
        .HWRITEM(hwrite_m[0]), .HSIZEM(hsize_m[0]), .HBURSTM(hburst_m[0]),
        .HPROTM(hprot_m[0]), .HBUSREQM(busreq_m[0]),
        .busy(busy_m[0]), .done(done_m[0]), .err(err_m[0])
    );

    ahb_seq_master #(.NUM_BEATS(3), .ADDR_INC(1)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .HREADYM(HREADYM), .HGRANTM(HGRANTM),
        .HRESPM(resp_m[1]), .start(start_m[1]),
        .HADDRM(haddr_m[1]), .HWDATAM(hwdata_m[1]), .HTRANSM(htrans_m[1]),
        .HWRITEM(hwrite_m[1]), .HSIZEM(hsize_m[1]), .HBURSTM(hburst_m[1]),
        .HPROTM(hprot_m[1]), .HBUSREQM(busreq_m[1]),
        .busy(busy_m[1]), .done(done_m[1]), .err(err_m[1])
    );

    // Reference model state, per master.
    int          nb     [2];
    int          ainc   [2];
    bit          act    [2];
    bit          dpend  [2];
    bit          abrt   [2];
    bit          err_e  [2];
    bit          done_e [2];
    bit          rst_e  [2];
    bit          p_hold [2];
    bit          p_idle [2];
    int          issued [2];
    int          dbeat  [2];
    logic [31:0] p_addr [2];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input int id, input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, id, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int id, input int i);
        return 32'h2000_0000 + 32'(i * 4 * ainc[id]);
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        return 32'h0000_0031 + 32'(i);
    endfunction

    // Check one master's outputs for the current cycle, then advance the model
    // with the inputs that the coming edge will sample.
    task automatic mon(input int id);
        logic       eb, nc, ef, old_dp;
        logic [1:0] ht;
        ht = htrans_m[id];
        chk(id, "fixed", 32'({hwrite_m[id], hsize_m[id], hburst_m[id], hprot_m[id]}), 32'h0000_0500);
        chk(id, "busy", 32'(busy_m[id]), 32'(act[id]));
        chk(id, "done", 32'(done_m[id]), 32'(done_e[id]));
        chk(id, "err", 32'(err_m[id]), 32'(err_e[id]));
        eb = act[id] && (issued[id] < nb[id]) && !abrt[id] && !done_e[id];
        chk(id, "busreq", 32'(busreq_m[id]), 32'(eb));
        if (!eb) chk(id, "htrans_idle", 32'(ht), 32'h0);
        else     chk(id, "htrans_legal", 32'(ht == 2'b00 || ht == 2'b10), 32'h1);
        if (p_hold[id]) begin
            chk(id, "hold_trans", 32'(ht), 32'h2);
            chk(id, "hold_addr", haddr_m[id], p_addr[id]);
        end
        if (p_idle[id]) chk(id, "idle_after", 32'(ht), 32'h0);
        if (dpend[id]) chk(id, "hwdata", hwdata_m[id], exp_data(dbeat[id]));
        if (ht == 2'b10) chk(id, "haddr", haddr_m[id], exp_addr(id, issued[id]));
        if (rst_e[id]) begin
            chk(id, "rst_haddr", haddr_m[id], 32'h2000_0000);
            chk(id, "rst_hwdata", hwdata_m[id], 32'h0);
        end

        if (HRESET) begin
            act[id] = 1'b0; dpend[id] = 1'b0; abrt[id] = 1'b0; err_e[id] = 1'b0;
            done_e[id] = 1'b0; issued[id] = 0; p_hold[id] = 1'b0; p_idle[id] = 1'b0;
            rst_e[id] = 1'b1;
        end else begin
            ef = dpend[id] && (resp_m[id] != 2'b00) && !HREADYM;
            p_hold[id] = (ht == 2'b10) && !HREADYM && !ef;
            p_idle[id] = ((ht == 2'b10) && HREADYM && !HGRANTM) || ef;
            p_addr[id] = haddr_m[id];
            rst_e[id]  = 1'b0;
            if (!act[id]) begin
                if (start_m[id]) begin
                    act[id] = 1'b1; issued[id] = 0; dpend[id] = 1'b0;
                    abrt[id] = 1'b0; err_e[id] = 1'b0;
                end
            end else if (done_e[id]) begin
                act[id] = 1'b0; done_e[id] = 1'b0; dpend[id] = 1'b0;
            end else begin
                old_dp = dpend[id];
                nc = (ht == 2'b10) && HREADYM && HGRANTM;
                if (ef) abrt[id] = 1'b1;
                if (old_dp && HREADYM) dpend[id] = 1'b0;
                if (nc) begin
                    dpend[id] = 1'b1;
                    dbeat[id] = issued[id];
                    issued[id]++;
                end else if (old_dp && HREADYM && (issued[id] == nb[id] || abrt[id])) begin
                    done_e[id] = 1'b1;
                    err_e[id]  = abrt[id];
                end
            end
        end
    endtask

    task automatic cyc();
        mon(0);
        mon(1);
        @(posedge HCLK);
        #1;
        start_m[0] = 1'b0; start_m[1] = 1'b0;
        resp_m[0]  = 2'b00; resp_m[1] = 2'b00;
        HRESET     = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        for (int k = 0; k < budget && (act[0] || act[1]); k++) cyc();
        chk(0, "run_complete", 32'({act[0], act[1]}), 32'h0);
    endtask

    task automatic wait_issued(input int id, input int n, input int budget);
        for (int k = 0; k < budget && issued[id] != n; k++) cyc();
        chk(id, "reach_beat", 32'(issued[id]), 32'(n));
    endtask

    initial begin
        int err_id;
        nb[0] = 4; nb[1] = 3; ainc[0] = 0; ainc[1] = 1;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; dpend[i] = 1'b0; abrt[i] = 1'b0; err_e[i] = 1'b0;
            done_e[i] = 1'b0; rst_e[i] = 1'b1; p_hold[i] = 1'b0; p_idle[i] = 1'b0;
            issued[i] = 0; dbeat[i] = 0; p_addr[i] = 32'h0;
            start_m[i] = 1'b0; resp_m[i] = 2'b00;
        end
        HRESET = 1'b1; HREADYM = 1'b1; HGRANTM = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        cyc();
        cyc();

        // Zero-wait runs on both masters (fixed and incrementing address).
        start_m[0] = 1'b1; start_m[1] = 1'b1;
        cyc();
        run_idle(40);

        // Two wait states in the data phase of beat 1.
        start_m[0] = 1'b1;
        cyc();
        wait_issued(0, 2, 20);
        HREADYM = 1'b0; cyc();
        HREADYM = 1'b0; cyc();
        HREADYM = 1'b1;
        run_idle(40);

        // Grant lost during beat 2's address phase.
        start_m[0] = 1'b1;
        cyc();
        wait_issued(0, 2, 20);
        HGRANTM = 1'b0; cyc(); cyc(); cyc();
        HGRANTM = 1'b1;
        run_idle(40);

        // ERROR response on beat 0, then a clean run clears err.
        start_m[0] = 1'b1;
        cyc();
        wait_issued(0, 1, 20);
        HREADYM = 1'b0; resp_m[0] = 2'b01; cyc();
        HREADYM = 1'b1; resp_m[0] = 2'b01; cyc();
        run_idle(40);
        start_m[0] = 1'b1;
        cyc();
        run_idle(40);

        // Reset in the middle of a transfer, start on the first edge after it.
        start_m[0] = 1'b1; start_m[1] = 1'b1;
        cyc();
        wait_issued(0, 2, 20);
        HRESET = 1'b1;
        cyc();
        start_m[0] = 1'b1;
        cyc();
        run_idle(40);

        // Random ready/grant/start with occasional fault responses.
        err_id = -1;
        for (int t = 0; t < 1500; t++) begin
            HREADYM = ($urandom_range(0, 4) != 0);
            HGRANTM = ($urandom_range(0, 6) != 0);
            start_m[0] = ($urandom_range(0, 5) == 0);
            start_m[1] = ($urandom_range(0, 5) == 0);
            if (err_id >= 0) begin
                HREADYM = 1'b1;
                resp_m[err_id] = 2'($urandom_range(1, 3));
                err_id = -1;
            end else if ($urandom_range(0, 29) == 0) begin
                int id;
                id = $urandom_range(0, 1);
                if (dpend[id] && !abrt[id] && !done_e[id]) begin
                    HREADYM = 1'b0;
                    resp_m[id] = 2'($urandom_range(1, 3));
                    err_id = id;
                end
            end
            cyc();
        end
        HREADYM = 1'b1; HGRANTM = 1'b1;
        run_idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_seq_master.md
AHB_SEQ_MASTER -- requirements
Module: ahb_seq_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h2000_0000, meaning address of beat 0.
REQ-002 Parameter NUM_BEATS, default 4, range 1..256, meaning beats per run.
REQ-003 Parameter ADDR_INC, default 0, meaning 0 = fixed address, 1 = address += 4 per beat.
REQ-004 Parameter DATA_INIT, default 32'h0000_0031, meaning HWDATAM of beat 0.
REQ-005 Parameter DATA_STEP, default 32'h0000_0001, meaning added to data per beat, modulo 2^32.
REQ-006 Parameter CONTINUOUS, default 0, meaning 1 = restart automatically after done.
REQ-007 Port HCLK, input, 1, meaning sole clock; all logic rising-edge.
REQ-008 Port HRESET, input, 1, meaning reset; synchronous and active-high.
REQ-009 Ports HREADYM, HGRANTM, input, 1 each, meaning AHB ready and grant; HRESPM, input, 2, meaning AHB response.
REQ-010 Port start, input, 1, meaning one-cycle run request.
REQ-011 Ports HADDRM (32), HWDATAM (32), HTRANSM (2), HWRITEM (1), HSIZEM (3), HBURSTM (3), HPROTM (4), HBUSREQM (1): outputs, AHB master signals.
REQ-012 Ports busy, done, err: outputs, 1 each; done is a one-cycle pulse, err is sticky until next start.

Function
REQ-013 HWRITEM SHALL be 1, HSIZEM 3'b010, HBURSTM 3'b000 (SINGLE) and HPROTM 4'b0000 at all times.
REQ-014 FSM states SHALL be IDLE, REQ, XFER, LAST, DONE.
REQ-015 IDLE: HBUSREQM=0, HTRANSM=IDLE; start=1 SHALL move to REQ, load beat=0, addr=BASE_ADDR, data=DATA_INIT, clear err.
REQ-016 start SHALL be ignored in all states except IDLE.
REQ-017 REQ: HBUSREQM=1, HTRANSM=IDLE; at an edge with HGRANTM=1 and HREADYM=1 SHALL move to XFER.
REQ-018 XFER: HTRANSM=NONSEQ, HADDRM=addr, HBUSREQM=1; a beat's address phase completes at an edge with HREADYM=1.
REQ-019 On address-phase completion the beat's data SHALL be registered onto HWDATAM for the next (data-phase) cycle, and addr/data/beat SHALL advance by ADDR_INC*4 / DATA_STEP / 1.
REQ-020 HWDATAM SHALL hold stable while HREADYM=0 in the data phase; address of the next beat overlaps that data phase (pipelined, one beat per cycle at zero wait states).
REQ-021 When the address phase of beat NUM_BEATS-1 completes, SHALL move to LAST with HTRANSM=IDLE and HBUSREQM=0.
REQ-022 If HGRANTM=0 at an edge with HREADYM=1 in XFER, SHALL return to REQ without advancing; the un-issued beat is reissued after regrant.
REQ-023 LAST: wait for HREADYM=1 ending the final data phase, then DONE.
REQ-024 DONE: done=1 for one cycle; next state REQ (reloaded as in REQ-015) if CONTINUOUS=1, else IDLE.
REQ-025 HRESPM=ERROR (2'b01) with HREADYM=0: HTRANSM SHALL be IDLE next cycle; at the following HREADYM=1 the FSM SHALL set err=1 and go to DONE without retrying.
REQ-026 HRESPM RETRY/SPLIT SHALL be treated as ERROR.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 addr SHALL wrap modulo 2^32; beat counter width SHALL be clog2(NUM_BEATS+1).

Reset
REQ-029 HRESET=1 at an edge SHALL force IDLE, HTRANSM=IDLE, HBUSREQM=0, HADDRM=BASE_ADDR, HWDATAM=0, busy=0, done=0, err=0, from any state including mid-transfer.
REQ-030 The first edge after HRESET falls SHALL behave as IDLE.

Structure
REQ-031 HTRANS/HSIZE/HBURST/HRESP encodings and the FSM state enum SHALL live in shared package ahb_pkg.
REQ-032 Beat address/data generation SHALL be sub-module ahb_beat_gen; FSM in the top.

Verification
REQ-033 Defaults, grant held, HREADYM=1, start pulse -> NONSEQ to 2000_0000 four cycles, HWDATAM 31,32,33,34, done one cycle after last data phase.
REQ-034 ADDR_INC=1, NUM_BEATS=3 -> HADDRM 2000_0000, 2000_0004, 2000_0008.
REQ-035 HREADYM=0 for 2 cycles in beat-1 data phase -> HWDATAM held at 32, HADDRM held at beat-2 address.
REQ-036 HGRANTM dropped after beat 1 -> HTRANSM IDLE, HBUSREQM stays 1, beat 2 reissued with data 33 after regrant.
REQ-037 HRESPM=ERROR on beat 0 -> HTRANSM IDLE next cycle, err=1, done pulse, no further beats.
REQ-038 HRESET asserted mid-XFER -> all outputs at REQ-029 values next cycle; start afterwards runs from beat 0.
